// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - nibble-serial wide adder sharing one external 4-bit slice
// between two round-robin requesters.
module nibble_add_sequencer #(
   parameter int NIBBLES = 8
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_ni,
   input  logic                   r0_valid_i,
   output logic                   r0_ready_o,
   input  logic [4*NIBBLES-1:0]   r0_a_i,
   input  logic [4*NIBBLES-1:0]   r0_b_i,
   input  logic                   r1_valid_i,
   output logic                   r1_ready_o,
   input  logic [4*NIBBLES-1:0]   r1_a_i,
   input  logic [4*NIBBLES-1:0]   r1_b_i,
   output logic                   res_valid_o,
   input  logic                   res_ready_i,
   output logic [4*NIBBLES-1:0]   res_sum_o,
   output logic                   res_co_o,
   output logic                   res_id_o,
   output logic [3:0]             nib_a_o,
   output logic [3:0]             nib_b_o,
   output logic                   nib_ci_o,
   input  logic [3:0]             nib_sum_i,
   input  logic                   nib_co_i,
   output logic                   busy_o
);

   localparam int W = 4*NIBBLES;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       state;
   state_t       state_nxt;

   logic [W-1:0] a_reg;
   logic [W-1:0] b_reg;
   logic [W-1:0] sum_reg;
   logic [W-1:0] sum_nxt;
   logic [W-1:0] res_sum_reg;
   logic         carry_reg;
   logic         res_co_reg;
   logic         res_id_reg;
   logic         id_reg;
   logic         ptr;
   logic [3:0]   idx;

   logic         gnt0;
   logic         gnt1;
   logic         take;
   logic         last_nib;

   // ptr holds the last granted id; on a tie the other requester wins.
   assign gnt0     = r0_valid_i && (!r1_valid_i || ptr);
   assign gnt1     = r1_valid_i && !gnt0;
   assign take     = (state == S_IDLE) && (gnt0 || gnt1);
   assign last_nib = (idx == 4'(NIBBLES-1));

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      r0_ready_o = 1'b0;
      r1_ready_o = 1'b0;
      case (state)
         S_IDLE: begin
            r0_ready_o = gnt0;
            r1_ready_o = gnt1;
            if (gnt0 || gnt1) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (last_nib) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready_i) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Nibble select toward the shared slice, and merge of its sum into the
   // running result. Constant part-selects keep the mux free of variable shifts.
   always_comb begin
      nib_a_o  = 4'd0;
      nib_b_o  = 4'd0;
      nib_ci_o = 1'b0;
      sum_nxt  = sum_reg;
      if (state == S_RUN) begin
         nib_ci_o = carry_reg;
         for (int i = 0; i < NIBBLES; i++) begin
            if (idx == 4'(i)) begin
               nib_a_o            = a_reg[4*i +: 4];
               nib_b_o            = b_reg[4*i +: 4];
               sum_nxt[4*i +: 4]  = nib_sum_i;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         a_reg       <= '0;
         b_reg       <= '0;
         sum_reg     <= '0;
         res_sum_reg <= '0;
         carry_reg   <= 1'b0;
         res_co_reg  <= 1'b0;
         res_id_reg  <= 1'b0;
         id_reg      <= 1'b0;
         ptr         <= 1'b1;
         idx         <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  a_reg     <= gnt1 ? r1_a_i : r0_a_i;
                  b_reg     <= gnt1 ? r1_b_i : r0_b_i;
                  id_reg    <= gnt1;
                  ptr       <= gnt1;
                  idx       <= 4'd0;
                  carry_reg <= 1'b0;
                  sum_reg   <= '0;
               end
            end
            S_RUN: begin
               sum_reg   <= sum_nxt;
               carry_reg <= nib_co_i;
               // Result registers load only here so they keep the previous
               // result while the next job is running.
               if (last_nib) begin
                  res_sum_reg <= sum_nxt;
                  res_co_reg  <= nib_co_i;
                  res_id_reg  <= id_reg;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign res_valid_o = (state == S_DONE);
   assign busy_o      = (state != S_IDLE);
   assign res_sum_o   = res_sum_reg;
   assign res_co_o    = res_co_reg;
   assign res_id_o    = res_id_reg;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - bench for nibble_add_sequencer: directed cases
// plus a randomized soak against a job-level reference model.
module tb_nibble_add_sequencer;

   localparam int NIB = 8;
   localparam int W   = 4*NIB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         r0_valid, r0_ready, r1_valid, r1_ready;
   logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
   logic         res_valid, res_ready, res_co, res_id, busy;
   logic [W-1:0] res_sum;
   logic [3:0]   nib_a, nib_b, nib_sum;
   logic         nib_ci, nib_co;

   logic         d1_valid, d1_ready, d1_r1_ready, d1_res_valid, d1_res_ready;
   logic [3:0]   d1_a, d1_b, d1_res_sum, d1_nib_a, d1_nib_b, d1_nib_sum;
   logic         d1_res_co, d1_res_id, d1_nib_ci, d1_nib_co, d1_busy;

   int n_checks = 0;
   int n_errors = 0;
   int res_cnt  = 0;
   bit f0, f1;

   always #5 clk = ~clk;

   assign {nib_co, nib_sum}       = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_ci};
   assign {d1_nib_co, d1_nib_sum} = {1'b0, d1_nib_a} + {1'b0, d1_nib_b} + {4'd0, d1_nib_ci};

   nibble_add_sequencer #(.NIBBLES(NIB)) u_dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_a_i(r0_a), .r0_b_i(r0_b),
      .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_a_i(r1_a), .r1_b_i(r1_b),
      .res_valid_o(res_valid), .res_ready_i(res_ready), .res_sum_o(res_sum),
      .res_co_o(res_co), .res_id_o(res_id),
      .nib_a_o(nib_a), .nib_b_o(nib_b), .nib_ci_o(nib_ci),
      .nib_sum_i(nib_sum), .nib_co_i(nib_co), .busy_o(busy)
   );

   nibble_add_sequencer #(.NIBBLES(1)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .r0_valid_i(d1_valid), .r0_ready_o(d1_ready), .r0_a_i(d1_a), .r0_b_i(d1_b),
      .r1_valid_i(1'b0), .r1_ready_o(d1_r1_ready), .r1_a_i(4'd0), .r1_b_i(4'd0),
      .res_valid_o(d1_res_valid), .res_ready_i(d1_res_ready), .res_sum_o(d1_res_sum),
      .res_co_o(d1_res_co), .res_id_o(d1_res_id),
      .nib_a_o(d1_nib_a), .nib_b_o(d1_nib_b), .nib_ci_o(d1_nib_ci),
      .nib_sum_i(d1_nib_sum), .nib_co_i(d1_nib_co), .busy_o(d1_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Job-level reference: one job in flight, result due NIB+1 cycles after
   // acceptance, nibble k carry-in is the carry out of the low 4k bits of a+b.
   bit          m_active = 1'b0;
   bit          m_ptr    = 1'b1;
   bit          m_id     = 1'b0;
   int          m_cyc    = 0;
   logic [63:0] m_a, m_b, m_tot, m_mask;
   bit          e_r0, e_r1, e_run, e_done;
   int          m_k;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_cyc    = 0;
         m_ptr    = 1'b1;
      end else begin
         e_r0   = !m_active && r0_valid && (!r1_valid || m_ptr);
         e_r1   = !m_active && r1_valid && !e_r0;
         e_run  = m_active && (m_cyc <= NIB);
         e_done = m_active && (m_cyc > NIB);
         check("mon_ready0", r0_ready, e_r0);
         check("mon_ready1", r1_ready, e_r1);
         check("mon_busy", busy, m_active);
         check("mon_res_valid", res_valid, e_done);
         if (e_run) begin
            m_k    = m_cyc - 1;
            m_mask = (64'd1 << (4*m_k)) - 64'd1;
            check("mon_nib_a", nib_a, (m_a >> (4*m_k)) & 64'hF);
            check("mon_nib_b", nib_b, (m_b >> (4*m_k)) & 64'hF);
            check("mon_nib_ci", nib_ci, ((m_a & m_mask) + (m_b & m_mask)) >> (4*m_k));
         end else begin
            check("mon_nib_idle", {nib_a, nib_b, nib_ci}, 0);
         end
         if (e_done) begin
            m_tot = m_a + m_b;
            check("mon_sum", res_sum, m_tot[31:0]);
            check("mon_co", res_co, m_tot[32]);
            check("mon_id", res_id, m_id);
         end
         if (e_r0 || e_r1) begin
            m_active = 1'b1;
            m_cyc    = 1;
            m_id     = e_r1;
            m_ptr    = e_r1;
            m_a      = {32'd0, (e_r1 ? r1_a : r0_a)};
            m_b      = {32'd0, (e_r1 ? r1_b : r0_b)};
         end else if (e_done && res_ready) begin
            m_active = 1'b0;
            res_cnt++;
         end else if (m_active) begin
            m_cyc++;
         end
      end
   end

   task automatic step();
      #1;
      f0 = r0_valid && r0_ready;
      f1 = r1_valid && r1_ready;
      @(posedge clk);
      #1;
      if (f0) r0_valid = 1'b0;
      if (f1) r1_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic id, input logic [W-1:0] sum, input logic co);
      bit seen = 1'b0;
      res_ready = 1'b1;
      for (int n = 0; n < 60 && !seen; n++) begin
         if (res_valid) begin
            seen = 1'b1;
            check({tag, "_id"}, res_id, id);
            check({tag, "_sum"}, res_sum, sum);
            check({tag, "_co"}, res_co, co);
         end
         step();
      end
      if (!seen) check({tag, "_timeout"}, 1'b0, 1'b1);
   endtask

   function automatic logic [W-1:0] rnd();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int sub, acc, res0, n;
      logic [W-1:0] held;
      rst_n = 1'b0;
      r0_valid = 1'b0; r1_valid = 1'b0; res_ready = 1'b0;
      r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
      d1_valid = 1'b0; d1_a = 4'd0; d1_b = 4'd0; d1_res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res", {res_sum, res_co, res_id}, 0);
      check("rst_nib", {nib_a, nib_b, nib_ci}, 0);
      check("rst_ready", {r0_ready, r1_ready}, 0);

      // simultaneous requests out of reset: r0 first, then r1
      r0_valid = 1'b1; r0_a = 32'h1234_5678; r0_b = 32'h1111_1111;
      r1_valid = 1'b1; r1_a = 32'h8000_0000; r1_b = 32'h8000_0000;
      #1;
      check("tie_ready0", r0_ready, 1);
      check("tie_ready1", r1_ready, 0);
      wait_result("tie_r0", 1'b0, 32'h2345_6789, 1'b0);
      wait_result("tie_r1", 1'b1, 32'h0000_0000, 1'b1);
      r0_valid = 1'b1; r0_a = 32'h0000_0001; r0_b = 32'h0000_0002;
      r1_valid = 1'b1; r1_a = 32'h0000_0010; r1_b = 32'h0000_0020;
      #1;
      check("tie2_ready0", r0_ready, 1);
      check("tie2_ready1", r1_ready, 0);
      wait_result("tie2_r0", 1'b0, 32'h0000_0003, 1'b0);
      wait_result("tie2_r1", 1'b1, 32'h0000_0030, 1'b0);

      // full carry ripple
      r0_valid = 1'b1; r0_a = 32'hFFFF_FFFF; r0_b = 32'h0000_0001; res_ready = 1'b1;
      #1 check("ripple_ready0", r0_ready, 1);
      step();
      for (int k = 0; k < NIB; k++) begin
         check("ripple_ci", nib_ci, (k > 0));
         check("ripple_nib_a", nib_a, 4'hF);
         check("ripple_valid_low", res_valid, 0);
         step();
      end
      check("ripple_valid", res_valid, 1);
      check("ripple_res", {res_sum, res_co, res_id}, {32'h0, 1'b1, 1'b0});
      step();

      // backpressure in DONE with r1 waiting
      res_ready = 1'b0;
      r0_valid = 1'b1; r0_a = 32'hA5A5_0F0F; r0_b = 32'h1234_F0F1;
      for (n = 0; n < 30 && !res_valid; n++) step();
      check("bp_reach_done", res_valid, 1);
      held = 32'hA5A5_0F0F + 32'h1234_F0F1;
      r1_valid = 1'b1; r1_a = 32'h0000_00FF; r1_b = 32'h0000_0001;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_valid", res_valid, 1);
         check("bp_sum", res_sum, held);
         check("bp_r1_ready", r1_ready, 0);
         check("bp_busy", busy, 1);
         step();
      end
      res_ready = 1'b1;
      step();
      check("bp_idle_ready1", r1_ready, 1);
      step();
      check("bp_accepted_busy", busy, 1);
      wait_result("bp_r1", 1'b1, 32'h0000_0100, 1'b0);

      // reset at nibble index 3
      r0_valid = 1'b1; r0_a = 32'h7777_7777; r0_b = 32'h9999_9999;
      step();
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_valid", res_valid, 0);
      check("mrst_res", {res_sum, res_co, res_id}, 0);
      check("mrst_nib", {nib_a, nib_b, nib_ci}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         check("mrst_no_result", res_valid, 0);
         step();
      end
      r1_valid = 1'b1; r1_a = 32'h0F0F_0F0F; r1_b = 32'hF0F0_F0F1;
      wait_result("mrst_next", 1'b1, 32'h0000_0000, 1'b1);

      // single-nibble instance
      d1_valid = 1'b1; d1_a = 4'hF; d1_b = 4'h1;
      #1 check("n1_ready", d1_ready, 1);
      @(posedge clk);
      #1 d1_valid = 1'b0;
      check("n1_run", {d1_busy, d1_res_valid, d1_nib_a, d1_nib_b}, {1'b1, 1'b0, 4'hF, 4'h1});
      @(posedge clk);
      #1;
      check("n1_valid", d1_res_valid, 1);
      check("n1_res", {d1_res_sum, d1_res_co, d1_res_id}, {4'h0, 1'b1, 1'b0});
      d1_res_ready = 1'b1;
      @(posedge clk);
      #1 check("n1_idle", d1_busy, 0);

      // random soak
      sub = 0; acc = 0; res0 = res_cnt;
      for (int cyc = 0; cyc < 40000 && !(acc == 1000 && res_cnt - res0 == 1000); cyc++) begin
         if (!r0_valid && sub < 1000 && $urandom_range(0, 1) == 1) begin
            r0_valid = 1'b1; r0_a = rnd(); r0_b = rnd(); sub++;
         end
         if (!r1_valid && sub < 1000 && $urandom_range(0, 1) == 1) begin
            r1_valid = 1'b1; r1_a = rnd(); r1_b = rnd(); sub++;
         end
         res_ready = ($urandom_range(0, 3) != 0);
         step();
         acc += int'(f0) + int'(f1);
      end
      check("soak_accepted", acc, 1000);
      check("soak_results", res_cnt - res0, 1000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Sequencing controller that shares one external 4-bit adder slice between two requesters and computes wide additions nibble-serially. It runs one nibble per clock, least significant first, with the carry held in a register between nibbles. The datapath is the existing combinational ripple adder extended with a carry-in. Each requester submits an operand pair over a valid/ready handshake, and a round-robin arbiter picks the next job. The block sits between the user-area logic (LA/IO/Wishbone glue) and the adder instance.

## Interface
- NIBBLES, default 8: operand width in nibbles. W = 4*NIBBLES. Legal range 1..16.
- wb_clk_i  input  1  single clock; all state changes on the rising edge
- wb_rst_ni  input  1  asynchronous, active-low reset
- r0_valid_i / r1_valid_i  input  1  requester 0/1 has an operand pair
- r0_ready_o / r1_ready_o  output  1  requester 0/1 is accepted this cycle
- r0_a_i, r0_b_i / r1_a_i, r1_b_i  input  W  operands of requester 0/1
- res_valid_o  output  1  result available
- res_ready_i  input  1  consumer takes the result
- res_sum_o  output  W  sum, mod 2^W
- res_co_o  output  1  carry out of the MSB nibble
- res_id_o  output  1  requester that owns the result (0/1)
- nib_a_o, nib_b_o  output  4  nibble operands driven to the adder slice
- nib_ci_o  output  1  carry-in driven to the adder slice
- nib_sum_i  input  4  adder slice sum (combinational from nib_*_o)
- nib_co_i  input  1  adder slice carry out
- busy_o  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE arbitration:
  - If exactly one valid_i is high, that requester is granted.
  - If both are high, the requester not granted most recently wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The granted requester's ready_o is high, combinationally from valid and the pointer. The other ready_o is low.
- Transfer occurs when valid and ready are both high at a clock edge. On that edge:
  - a, b and the id are captured into internal registers.
  - nibble index is set to 0; carry register is set to 0; sum register is cleared.
  - the pointer is updated to the granted id; state goes to RUN.
- ready_o is low in RUN and DONE. Requesters hold valid and their operands until accepted. Operands are sampled only on the transfer edge.
- RUN, at nibble index k:
  - nib_a_o = a_reg[4k+3:4k], nib_b_o = b_reg[4k+3:4k], nib_ci_o = carry_reg.
  - On the edge: sum_reg[4k+3:4k] <= nib_sum_i, carry_reg <= nib_co_i, k <= k+1.
  - When k = NIBBLES-1, the edge moves to DONE instead of incrementing.
- nib_a_o, nib_b_o and nib_ci_o are 0 outside RUN.
- DONE:
  - res_valid_o is high; res_sum_o = sum_reg, res_co_o = carry_reg, res_id_o = id_reg.
  - All four are held stable until res_ready_i is high at an edge, which moves to IDLE.
  - No new job is accepted while in DONE.
- Arithmetic: res_sum_o = (a + b) mod 2^W; res_co_o = bit W of a + b. The requester carry-in is fixed at 0.
- res_sum_o, res_co_o and res_id_o retain their last values outside DONE, but are qualified only by res_valid_o.
- Reset values (asynchronous, on wb_rst_ni low):
  - state IDLE, pointer 1, all registers 0.
  - res_valid_o 0, res_sum_o 0, res_co_o 0, res_id_o 0, busy_o 0.
  - nib_* outputs 0. ready_o follows IDLE arbitration once reset is released.
- Reset mid-operation: the job in flight is discarded. No result is produced and the requester is not re-acknowledged.

## Timing
- Acceptance edge E0: RUN is active for cycles E0+1 .. E0+NIBBLES.
- res_valid_o rises after edge E0+NIBBLES, i.e. it is visible in cycle NIBBLES+1 after acceptance.
- Consumed on edge Ec: the block is in IDLE in the next cycle and can accept on the edge after that.
- Minimum job spacing is NIBBLES+2 cycles with res_ready_i tied high.
- The adder slice path nib_*_o -> nib_sum_i/nib_co_i -> registers is one combinational cycle. No multicycle path.
- ready_o is a combinational function of valid_i, state and pointer. There is no combinational path from res_ready_i to ready_o.
- If a valid_i drops before a grant edge, nothing transfers. Grant is re-evaluated every IDLE cycle.

## Test plan
- NIBBLES=8. r0 sends a=0xFFFFFFFF, b=0x00000001 -> after 8 RUN cycles: res_sum_o=0x00000000, res_co_o=1, res_id_o=0, res_valid_o high in cycle 9 after acceptance. nib_ci_o=1 on nibbles 1..7.
- Both valid out of reset: r0 sends 0x12345678+0x11111111, r1 sends 0x80000000+0x80000000 -> r0 is served first (sum 0x23456789, co 0), then r1 (sum 0x00000000, co 1, id 1). A second simultaneous pair goes to r0 again only after r1 has been served.
- Backpressure: hold res_ready_i low for 5 cycles in DONE with r1_valid_i high -> res_* stay stable, r1_ready_o stays 0, busy_o stays 1. Release -> the r1 job is accepted 2 cycles later.
- Reset mid-RUN: assert wb_rst_ni low at nibble index 3 -> state immediately goes to IDLE and all outputs take their reset values. No res_valid_o pulse for that job. The next job completes correctly.
- NIBBLES=1: a=0xF, b=0x1 -> sum 0x0, co 1, res_valid_o in cycle 2 after acceptance.
- Random soak with 1000 jobs, random valid/ready and random operands -> every result matches the (a+b) reference model with the correct id, and no job is lost or duplicated.
